// File: rtl/display_seq_timed.sv
// Colour sequence player: latches a packed sequence on start and shows round_ctr+1
// entries, forward or reverse, each held for on_cycles and separated by gap_cycles blanks.
module display_seq_timed #(
  parameter int COLOUR_W = 2,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 4,
  parameter int TIME_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         reverse,
  input  logic [COLOUR_W*MAX_LEN-1:0]  seq_in,
  input  logic [LEN_W-1:0]             round_ctr,
  input  logic [TIME_W-1:0]            on_cycles,
  input  logic [TIME_W-1:0]            gap_cycles,
  output logic [COLOUR_W-1:0]          colour_bus,
  output logic                         colour_oe,
  output logic                         colour_strobe,
  output logic                         busy,
  output logic                         complete
);

  localparam logic [LEN_W-1:0] LAST_MAX = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                        state_q;
  logic [COLOUR_W*MAX_LEN-1:0]   seq_q;
  logic                          rev_q;
  logic [TIME_W-1:0]             on_q;
  logic [TIME_W-1:0]             gap_q;
  logic [LEN_W-1:0]              last_q;
  logic [LEN_W-1:0]              pos_q;
  logic [TIME_W-1:0]             timer_q;
  logic [COLOUR_W-1:0]           bus_q;
  logic                          oe_q;
  logic                          strobe_q;
  logic                          busy_q;
  logic                          complete_q;

  logic [LEN_W-1:0]              last_d;
  logic [TIME_W-1:0]             on_d;
  logic [LEN_W-1:0]              start_pos_d;
  logic [LEN_W-1:0]              next_pos_d;
  logic                          is_last_d;
  logic [COLOUR_W-1:0]           start_colour_d;
  logic [COLOUR_W-1:0]           next_colour_d;

  // next_pos_d may step past the sequence after the final entry; it is never used then.
  always_comb begin
    last_d         = (round_ctr > LAST_MAX) ? LAST_MAX : round_ctr;
    on_d           = (on_cycles == '0) ? TIME_W'(1) : on_cycles;
    start_pos_d    = reverse ? last_d : '0;
    next_pos_d     = rev_q ? (pos_q - 1'b1) : (pos_q + 1'b1);
    is_last_d      = rev_q ? (pos_q == '0) : (pos_q == last_q);
    start_colour_d = seq_in[start_pos_d*COLOUR_W +: COLOUR_W];
    next_colour_d  = seq_q[next_pos_d*COLOUR_W +: COLOUR_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      rev_q      <= 1'b0;
      on_q       <= '0;
      gap_q      <= '0;
      last_q     <= '0;
      pos_q      <= '0;
      timer_q    <= '0;
      bus_q      <= '0;
      oe_q       <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else if (abort) begin
      state_q    <= IDLE;
      bus_q      <= '0;
      oe_q       <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          complete_q <= 1'b0;
          strobe_q   <= 1'b0;
          bus_q      <= '0;
          oe_q       <= 1'b0;
          busy_q     <= 1'b0;
          if (start) begin
            state_q  <= SHOW;
            seq_q    <= seq_in;
            rev_q    <= reverse;
            on_q     <= on_d;
            gap_q    <= gap_cycles;
            last_q   <= last_d;
            pos_q    <= start_pos_d;
            timer_q  <= TIME_W'(1);
            bus_q    <= start_colour_d;
            oe_q     <= 1'b1;
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SHOW: begin
          strobe_q <= 1'b0;
          if (timer_q == on_q) begin
            timer_q <= TIME_W'(1);
            if (is_last_d) begin
              state_q    <= IDLE;
              bus_q      <= '0;
              oe_q       <= 1'b0;
              busy_q     <= 1'b0;
              complete_q <= 1'b1;
            end else if (gap_q == '0) begin
              pos_q    <= next_pos_d;
              bus_q    <= next_colour_d;
              strobe_q <= 1'b1;
            end else begin
              state_q <= GAP;
              bus_q   <= '0;
              oe_q    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        GAP: begin
          strobe_q <= 1'b0;
          if (timer_q == gap_q) begin
            state_q  <= SHOW;
            pos_q    <= next_pos_d;
            timer_q  <= TIME_W'(1);
            bus_q    <= next_colour_d;
            oe_q     <= 1'b1;
            strobe_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          bus_q      <= '0;
          oe_q       <= 1'b0;
          strobe_q   <= 1'b0;
          busy_q     <= 1'b0;
          complete_q <= 1'b0;
        end
      endcase
    end
  end

  assign colour_bus    = bus_q;
  assign colour_oe     = oe_q;
  assign colour_strobe = strobe_q;
  assign busy          = busy_q;
  assign complete      = complete_q;

endmodule

// File: tb/tb_display_seq_timed.sv
// Bench for display_seq_timed: a 16-entry and a 12-entry instance are driven with
// directed and random plays and compared cycle by cycle against a trace model.
module tb_display_seq_timed;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start16;
  logic        start12;
  logic        abort;
  logic        reverse;
  logic [31:0] seq16;
  logic [23:0] seq12;
  logic [3:0]  roundCtr;
  logic [7:0]  onCycles;
  logic [7:0]  gapCycles;

  logic [1:0]  bus16, bus12;
  logic        oe16, oe12, stb16, stb12, busy16, busy12, cmp16, cmp12;

  int          numChecks = 0;
  int          numFails  = 0;
  bit          sel = 1'b0;
  logic [5:0]  expQ[$];

  always #5 clk = ~clk;

  display_seq_timed dut16 (
    .clk(clk), .rst_n(rstN), .start(start16), .abort(abort), .reverse(reverse),
    .seq_in(seq16), .round_ctr(roundCtr), .on_cycles(onCycles), .gap_cycles(gapCycles),
    .colour_bus(bus16), .colour_oe(oe16), .colour_strobe(stb16), .busy(busy16),
    .complete(cmp16)
  );

  display_seq_timed #(.MAX_LEN(12)) dut12 (
    .clk(clk), .rst_n(rstN), .start(start12), .abort(abort), .reverse(reverse),
    .seq_in(seq12), .round_ctr(roundCtr), .on_cycles(onCycles), .gap_cycles(gapCycles),
    .colour_bus(bus12), .colour_oe(oe12), .colour_strobe(stb12), .busy(busy12),
    .complete(cmp12)
  );

  // Observed vector layout: {oe, bus[1:0], strobe, busy, complete}.
  task automatic checkOutput(input string tag, input logic [5:0] expV);
    logic [5:0] obs;
    obs = sel ? {oe12, bus12, stb12, busy12, cmp12} : {oe16, bus16, stb16, busy16, cmp16};
    numChecks++;
    assert (obs === expV) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expV);
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_idle%0d", tag, i), 6'b0);
    end
  endtask

  // Expected per-cycle trace from the cycle after start up to the complete pulse.
  task automatic buildTrace(input logic [31:0] seqv, input int n, input int on,
                            input int gap, input bit rev);
    int maxLen, last, onEff, idx;
    logic [1:0] colour;
    maxLen = sel ? 12 : 16;
    last   = (n > maxLen - 1) ? maxLen - 1 : n;
    onEff  = (on == 0) ? 1 : on;
    expQ.delete();
    for (int k = 0; k <= last; k++) begin
      idx    = rev ? last - k : k;
      colour = seqv[idx*2 +: 2];
      for (int c = 0; c < onEff; c++) expQ.push_back({1'b1, colour, (c == 0), 1'b1, 1'b0});
      if (k < last)
        for (int g = 0; g < gap; g++) expQ.push_back(6'b000010);
    end
    expQ.push_back(6'b000001);
  endtask

  // Called at a negedge while the selected instance is idle; start is sampled at the next edge.
  task automatic applyStimulus(input logic [31:0] seqv, input int n, input int on,
                               input int gap, input bit rev);
    seq16     = seqv;
    seq12     = seqv[23:0];
    roundCtr  = 4'(n);
    onCycles  = 8'(on);
    gapCycles = 8'(gap);
    reverse   = rev;
    if (sel) start12 = 1'b1; else start16 = 1'b1;
    buildTrace(seqv, n, on, gap, rev);
  endtask

  task automatic scramble();
    if (sel) start12 = 1'($urandom); else start16 = 1'($urandom);
    seq16     = $urandom;
    seq12     = 24'($urandom);
    roundCtr  = 4'($urandom);
    onCycles  = 8'($urandom);
    gapCycles = 8'($urandom);
    reverse   = 1'($urandom);
  endtask

  // Walks the trace; cutAt >= 0 interrupts with abort or reset after that cycle.
  task automatic follow(input string tag, input bit noise, input int cutAt, input bit useReset);
    for (int k = 0; k < expQ.size(); k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s[%0d]", tag, k), expQ[k]);
      if (k == cutAt) begin
        if (noise) scramble();
        if (useReset) rstN = 1'b0; else abort = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("%s_cut", tag), 6'b0);
        rstN = 1'b1; abort = 1'b0; start16 = 1'b0; start12 = 1'b0;
        checkIdle(tag, 2);
        return;
      end
      if (noise && expQ[k][1]) scramble();
      else begin
        start16 = 1'b0;
        start12 = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] rs;
    rstN = 1'b0; start16 = 1'b1; start12 = 1'b1; abort = 1'b0; reverse = 1'b0;
    seq16 = 32'hE4; seq12 = 24'hE4; roundCtr = 4'd3; onCycles = 8'd2; gapCycles = 8'd1;

    checkIdle("reset_hold", 3);
    sel = 1'b1;
    checkOutput("reset_hold12", 6'b0);
    sel = 1'b0;
    rstN = 1'b1; start16 = 1'b0; start12 = 1'b0;
    checkIdle("reset_release", 3);

    applyStimulus(32'h000000E4, 3, 2, 1, 1'b0);
    follow("fwd_on2_gap1", 1'b0, -1, 1'b0);
    checkIdle("fwd_on2_gap1", 2);

    applyStimulus(32'h000000E4, 3, 0, 0, 1'b1);
    follow("rev_on0_gap0", 1'b0, -1, 1'b0);
    checkIdle("rev_on0_gap0", 2);

    applyStimulus(32'h00000003, 0, 1, 5, 1'b0);
    follow("single", 1'b0, -1, 1'b0);
    checkIdle("single", 2);

    applyStimulus(32'h000000E4, 3, 2, 1, 1'b0);
    follow("abort_gap2", 1'b1, 5, 1'b0);

    applyStimulus(32'h000000E4, 3, 2, 1, 1'b0);
    follow("noise_full", 1'b1, -1, 1'b0);
    checkIdle("noise_full", 1);

    applyStimulus($urandom, 7, 1, 2, 1'b1);
    follow("reset_mid", 1'b1, 3, 1'b1);

    sel = 1'b1;
    rs = $urandom;
    applyStimulus(rs, 15, 1, 0, 1'b0);
    follow("len12_fwd", 1'b0, -1, 1'b0);
    applyStimulus(rs, 15, 2, 1, 1'b1);
    follow("len12_restart", 1'b1, -1, 1'b0);
    checkIdle("len12_restart", 2);

    for (int it = 0; it < 12; it++) begin
      sel = 1'($urandom);
      applyStimulus($urandom, $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom));
      if (it % 4 == 3) follow($sformatf("rand%0d", it), 1'b1, $urandom_range(0, 4), 1'b0);
      else begin
        follow($sformatf("rand%0d", it), 1'b1, -1, 1'b0);
        checkIdle($sformatf("rand%0d", it), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
